// File: rtl/mc_controller_if.sv
// Control bundle between the multicycle main FSM and the MIPS datapath/memory.
// The master side is the controller; the slave side is the datapath.
interface mc_controller_if;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
    logic       illegal_op;
    logic [3:0] state;

    modport master (
        input  op, zero, mem_ready,
        output mem_req, mem_write, iord, ir_write, pc_en, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
               mem_to_reg, instr_done, illegal_op, state
    );

    modport slave (
        output op, zero, mem_ready,
        input  mem_req, mem_write, iord, ir_write, pc_en, pc_src,
               alu_src_a, alu_src_b, alu_op, reg_write, reg_dst,
               mem_to_reg, instr_done, illegal_op, state
    );
endinterface

// File: rtl/mc_controller.sv
// Moore main control FSM for the multicycle MIPS core: one state register,
// all datapath controls decoded combinationally from state (plus mem_ready/zero).
module mc_controller (
    input  logic              clk,
    input  logic              rst,
    mc_controller_if.master   bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        REX    = 4'd6,
        RWB    = 4'd7,
        BEQEX  = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JEX    = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state_q;
    logic   pc_write;
    logic   branch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            case (state_q)
                FETCH:  if (bus.mem_ready) state_q <= DECODE;
                DECODE: begin
                    case (bus.op)
                        OP_LW, OP_SW: state_q <= MEMADR;
                        OP_R:         state_q <= REX;
                        OP_BEQ:       state_q <= BEQEX;
                        OP_ADDI:      state_q <= ADDIEX;
                        OP_J:         state_q <= JEX;
                        default:      state_q <= FETCH;
                    endcase
                end
                MEMADR: state_q <= (bus.op == OP_SW) ? MEMWR : MEMRD;
                MEMRD:  if (bus.mem_ready) state_q <= MEMWB;
                MEMWR:  if (bus.mem_ready) state_q <= FETCH;
                REX:    state_q <= RWB;
                ADDIEX: state_q <= ADDIWB;
                MEMWB, RWB, BEQEX, ADDIWB, JEX: state_q <= FETCH;
                // Codes 12-15 are unreachable; recover to FETCH if ever entered.
                default: state_q <= FETCH;
            endcase
        end
    end

    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_write  = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_src     = 2'b00;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.instr_done = 1'b0;
        bus.illegal_op = 1'b0;
        pc_write       = 1'b0;
        branch         = 1'b0;
        case (state_q)
            FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.ir_write  = bus.mem_ready;
                pc_write      = bus.mem_ready;
            end
            DECODE: begin
                bus.alu_src_b  = 2'b11;
                bus.illegal_op = !(bus.op == OP_LW || bus.op == OP_SW ||
                                   bus.op == OP_R || bus.op == OP_BEQ ||
                                   bus.op == OP_ADDI || bus.op == OP_J);
            end
            MEMADR, ADDIEX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
            end
            // Request stays asserted through the wait; done only when memory accepts.
            MEMWR: begin
                bus.mem_req    = 1'b1;
                bus.mem_write  = 1'b1;
                bus.iord       = 1'b1;
                bus.instr_done = bus.mem_ready;
            end
            REX: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
            end
            RWB: begin
                bus.reg_write  = 1'b1;
                bus.reg_dst    = 1'b1;
                bus.instr_done = 1'b1;
            end
            BEQEX: begin
                bus.alu_src_a  = 1'b1;
                bus.alu_op     = 2'b01;
                bus.pc_src     = 2'b01;
                branch         = 1'b1;
                bus.instr_done = 1'b1;
            end
            ADDIWB: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
            end
            JEX: begin
                bus.pc_src     = 2'b10;
                pc_write       = 1'b1;
                bus.instr_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.pc_en = pc_write | (branch & bus.zero);
    assign bus.state = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed-vector bench for mc_controller: the driver queues hand-computed
// per-cycle expectations, an independent monitor pops and compares them.
module tb_mc_controller;

    logic clk = 1'b0;
    logic rst;

    mc_controller_if bus ();

    mc_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Output vector order:
    // {mem_req, mem_write, iord, ir_write, pc_en, pc_src[1:0], alu_src_a,
    //  alu_src_b[1:0], alu_op[1:0], reg_write, reg_dst, mem_to_reg, instr_done, illegal_op}
    localparam logic [16:0] F0    = 17'b1_0_0_0_0_00_0_01_00_0_0_0_0_0;
    localparam logic [16:0] F1    = 17'b1_0_0_1_1_00_0_01_00_0_0_0_0_0;
    localparam logic [16:0] DEC   = 17'b0_0_0_0_0_00_0_11_00_0_0_0_0_0;
    localparam logic [16:0] DECIL = 17'b0_0_0_0_0_00_0_11_00_0_0_0_0_1;
    localparam logic [16:0] MADR  = 17'b0_0_0_0_0_00_1_10_00_0_0_0_0_0;
    localparam logic [16:0] MRD   = 17'b1_0_1_0_0_00_0_00_00_0_0_0_0_0;
    localparam logic [16:0] MWB   = 17'b0_0_0_0_0_00_0_00_00_1_0_1_1_0;
    localparam logic [16:0] MWR0  = 17'b1_1_1_0_0_00_0_00_00_0_0_0_0_0;
    localparam logic [16:0] MWR1  = 17'b1_1_1_0_0_00_0_00_00_0_0_0_1_0;
    localparam logic [16:0] REXO  = 17'b0_0_0_0_0_00_1_00_10_0_0_0_0_0;
    localparam logic [16:0] RWBO  = 17'b0_0_0_0_0_00_0_00_00_1_1_0_1_0;
    localparam logic [16:0] BEQ1  = 17'b0_0_0_0_1_01_1_00_01_0_0_0_1_0;
    localparam logic [16:0] BEQ0  = 17'b0_0_0_0_0_01_1_00_01_0_0_0_1_0;
    localparam logic [16:0] ADDX  = 17'b0_0_0_0_0_00_1_10_00_0_0_0_0_0;
    localparam logic [16:0] ADDW  = 17'b0_0_0_0_0_00_0_00_00_1_0_0_1_0;
    localparam logic [16:0] JEXO  = 17'b0_0_0_0_1_10_0_00_00_0_0_0_1_0;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct {
        int          cycle;
        logic [3:0]  st;
        logic [16:0] outs;
    } exp_t;

    exp_t expQueue[$];
    int   compared = 0;
    int   mismatched = 0;
    int   issued = 0;
    bit   driverDone = 0;

    function automatic logic [16:0] sampleOuts();
        return {bus.mem_req, bus.mem_write, bus.iord, bus.ir_write, bus.pc_en,
                bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.instr_done,
                bus.illegal_op};
    endfunction

    // Drive one cycle of inputs just after the edge and queue what the outputs must be.
    task automatic applyStimulus(input logic r, input logic [5:0] o, input logic z,
                                 input logic rdy, input logic [3:0] st,
                                 input logic [16:0] outs);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        bus.op        = o;
        bus.zero      = z;
        bus.mem_ready = rdy;
        e.cycle = issued;
        e.st    = st;
        e.outs  = outs;
        expQueue.push_back(e);
        issued++;
    endtask

    task automatic checkOutput(input exp_t e);
        logic [16:0] got;
        got = sampleOuts();
        compared++;
        if (bus.state !== e.st) begin
            mismatched++;
            $display("[TB] FAIL cycle%0d state: got %0d expected %0d", e.cycle, bus.state, e.st);
        end
        compared++;
        if (got !== e.outs) begin
            mismatched++;
            $display("[TB] FAIL cycle%0d outputs: got %b expected %b", e.cycle, got, e.outs);
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (expQueue.size() > 0) checkOutput(expQueue.pop_front());
        end
    end

    initial begin : driver
        rst = 1'b1;
        bus.op = OP_R;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;

        // Reset held with memory not ready, then a fetch completes
        applyStimulus(1, OP_LW, 0, 0, 4'd0, F0);
        applyStimulus(1, OP_LW, 0, 0, 4'd0, F0);
        applyStimulus(0, OP_LW, 0, 0, 4'd0, F0);
        // lw, zero-wait
        applyStimulus(0, OP_LW, 0, 1, 4'd0, F1);
        applyStimulus(0, OP_LW, 0, 1, 4'd1, DEC);
        applyStimulus(0, OP_LW, 0, 1, 4'd2, MADR);
        applyStimulus(0, OP_LW, 0, 1, 4'd3, MRD);
        applyStimulus(0, OP_LW, 0, 1, 4'd4, MWB);
        // sw with two wait cycles in MEMWR
        applyStimulus(0, OP_SW, 0, 1, 4'd0, F1);
        applyStimulus(0, OP_SW, 0, 1, 4'd1, DEC);
        applyStimulus(0, OP_SW, 0, 1, 4'd2, MADR);
        applyStimulus(0, OP_SW, 0, 0, 4'd5, MWR0);
        applyStimulus(0, OP_SW, 0, 0, 4'd5, MWR0);
        applyStimulus(0, OP_SW, 0, 1, 4'd5, MWR1);
        // beq taken
        applyStimulus(0, OP_BEQ, 1, 1, 4'd0, F1);
        applyStimulus(0, OP_BEQ, 1, 1, 4'd1, DEC);
        applyStimulus(0, OP_BEQ, 1, 1, 4'd8, BEQ1);
        // beq not taken
        applyStimulus(0, OP_BEQ, 0, 1, 4'd0, F1);
        applyStimulus(0, OP_BEQ, 0, 1, 4'd1, DEC);
        applyStimulus(0, OP_BEQ, 0, 1, 4'd8, BEQ0);
        // unsupported opcode
        applyStimulus(0, OP_BAD, 0, 1, 4'd0, F1);
        applyStimulus(0, OP_BAD, 0, 1, 4'd1, DECIL);
        // jump
        applyStimulus(0, OP_J, 0, 1, 4'd0, F1);
        applyStimulus(0, OP_J, 0, 1, 4'd1, DEC);
        applyStimulus(0, OP_J, 0, 1, 4'd11, JEXO);
        // addi
        applyStimulus(0, OP_ADDI, 0, 1, 4'd0, F1);
        applyStimulus(0, OP_ADDI, 0, 1, 4'd1, DEC);
        applyStimulus(0, OP_ADDI, 0, 1, 4'd9, ADDX);
        applyStimulus(0, OP_ADDI, 0, 1, 4'd10, ADDW);
        // sw interrupted by reset during the memory wait
        applyStimulus(0, OP_SW, 0, 1, 4'd0, F1);
        applyStimulus(0, OP_SW, 0, 1, 4'd1, DEC);
        applyStimulus(0, OP_SW, 0, 1, 4'd2, MADR);
        applyStimulus(0, OP_SW, 0, 0, 4'd5, MWR0);
        applyStimulus(1, OP_SW, 0, 0, 4'd5, MWR0);
        applyStimulus(0, OP_SW, 0, 0, 4'd0, F0);
        // R-type afterwards
        applyStimulus(0, OP_R, 0, 1, 4'd0, F1);
        applyStimulus(0, OP_R, 0, 1, 4'd1, DEC);
        applyStimulus(0, OP_R, 0, 1, 4'd6, REXO);
        applyStimulus(0, OP_R, 0, 1, 4'd7, RWBO);
        applyStimulus(0, OP_R, 0, 0, 4'd0, F0);
        driverDone = 1;
    end

    initial begin : finisher
        int budget;
        budget = 0;
        while (!(driverDone && expQueue.size() == 0) && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        @(posedge clk);
        compared++;
        if (expQueue.size() != 0 || !driverDone) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d entries left, required 0", expQueue.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Moore-style main control FSM for the multicycle MIPS core. Sequences the shared datapath (single memory port, single ALU, IR, PC) one instruction at a time. Stalls on a memory-ready handshake. Drives the 2-bit ALU-op code consumed by the existing ALU-function decoder. Sits between the instruction register's opcode field and the datapath mux/enable controls.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- op  in  6  opcode field from instruction register (IR[31:26])
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  write strobe (valid with mem_req)
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- ir_write  out  1  load IR
- pc_en  out  1  PC load enable = pc_write | (branch & zero)
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
- alu_src_a  out  1  0=PC, 1=register A
- alu_src_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- alu_op  out  2  00=add, 01=subtract, 10=use funct
- reg_write  out  1  register file write enable
- reg_dst  out  1  0=rt, 1=rd
- mem_to_reg  out  1  0=ALUOut, 1=memory data
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- state  out  4  current state (debug/verification)

## Operation
- States/encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REX=6, RWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12-15 unreachable; if entered, next state FETCH.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, j=000010.
- Every output not listed for a state is 0. Internal pc_write/branch terms are 0 unless listed.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write=pc_write=mem_ready. Stay while mem_ready=0; else to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next by op: lw/sw->MEMADR, R->REX, beq->BEQEX, addi->ADDIEX, j->JEX. Any other op: illegal_op=1, next FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEMRD for lw, MEMWR for sw. op is re-read here; IR is stable.
- MEMRD: mem_req=1, iord=1. Stay until mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1. Next FETCH.
- MEMWR: mem_req=1, mem_write=1, iord=1. Held until mem_ready. instr_done=mem_ready. Next FETCH on mem_ready.
- REX: alu_src_a=1, alu_src_b=00, alu_op=10. Next RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Next FETCH.
- BEQEX: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1, instr_done=1. Next FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Next FETCH.
- JEX: pc_src=10, pc_write=1, instr_done=1. Next FETCH.

## Timing
- Only the state register is sequential. All outputs are combinational from state, plus mem_ready/zero where stated. No output register stage.
- Reset: state=FETCH on the edge with rst=1. Outputs then show FETCH values: mem_req=1, alu_src_b=01, all enables 0 unless mem_ready=1.
- rst overrides all transitions, including mid-instruction and during a memory wait. mem_write drops the cycle after the reset edge.
- Zero-wait latency in cycles: lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2. Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds 1 cycle.
- mem_req and iord are stable for the whole wait. The memory must not see request changes until mem_ready.
- pc_en in BEQEX depends on the same-cycle zero only.

## Test plan
- Reset with mem_ready=0 held for 3 cycles -> state=0, mem_req=1, ir_write=0, pc_en=0 throughout. Then mem_ready=1 -> ir_write=pc_en=1 for one cycle, then state=1.
- lw (op=100011), mem_ready=1 always -> states 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in cycle 5. instr_done pulses once.
- sw (op=101011), mem_ready=0 for 2 cycles in MEMWR -> mem_write=1 for 3 cycles. reg_write never set. instr_done coincides with mem_ready.
- beq (op=000100) with zero=1 -> pc_en=1, pc_src=01 in BEQEX. Repeat with zero=0 -> pc_en=0. Both return to FETCH.
- op=111111 -> illegal_op=1 in DECODE, next state 0. No reg_write/mem_write/pc_en.
- rst=1 while in MEMWR waiting -> state=0 next cycle, mem_write=0. R-type (op=000000) afterwards -> alu_op=10 in REX, reg_dst=1 in RWB.
